// File: rtl/uart_tx_fifo_if.sv
// Host write port, status flags and uart handshake of the transmit FIFO.
// slave is the FIFO's view; master is the host/uart side driving it.
interface uart_tx_fifo_if #(
  parameter int ADDR_W = 4
);
  logic [7:0]      wr_data;
  logic            wr_en;
  logic            clr_flags;
  logic            full;
  logic            empty;
  logic [ADDR_W:0] count;
  logic            overflow;
  logic            ack_timeout;
  logic [7:0]      send_data;
  logic            start;
  logic            busy;

  modport slave (
    input  wr_data, wr_en, clr_flags, busy,
    output full, empty, count, overflow, ack_timeout, send_data, start
  );

  modport master (
    output wr_data, wr_en, clr_flags, busy,
    input  full, empty, count, overflow, ack_timeout, send_data, start
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// Transmit FIFO in front of the uart: buffers host bytes in a circular store
// and hands them out one at a time over the send_data/start/busy handshake.
module uart_tx_fifo #(
  parameter int ADDR_W      = 4,
  parameter int ACK_TIMEOUT = 8
) (
  input  logic          clock,
  input  logic          reset,
  uart_tx_fifo_if.slave bus
);
  localparam int              DEPTH      = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_CNT  = (ADDR_W + 1)'(DEPTH);
  localparam logic [7:0]      TIMER_LAST = 8'(ACK_TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, WAIT_ACK, WAIT_DONE} state_t;

  state_t            state_reg, state_next;
  logic [7:0]        mem [DEPTH];
  logic [ADDR_W-1:0] rd_ptr_reg, wr_ptr_reg;
  logic [ADDR_W:0]   count_reg;
  logic [7:0]        timer_reg, timer_next;
  logic [7:0]        send_data_reg;
  logic              start_reg, overflow_reg, ack_timeout_reg;
  logic              full, empty, pop, push, drop, timeout_hit;

  assign full  = (count_reg == DEPTH_CNT);
  assign empty = (count_reg == '0);
  // A pop in the same cycle frees a slot, so a write while full still lands.
  assign push  = bus.wr_en && (!full || pop);
  assign drop  = bus.wr_en && !push;

  always_comb begin
    state_next  = state_reg;
    timer_next  = timer_reg;
    pop         = 1'b0;
    timeout_hit = 1'b0;
    unique case (state_reg)
      IDLE: begin
        if (!empty && !bus.busy) begin
          pop        = 1'b1;
          timer_next = '0;
          state_next = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (bus.busy) begin
          state_next = WAIT_DONE;
        end else if (timer_reg == TIMER_LAST) begin
          // The byte is treated as consumed; it is not retried.
          timeout_hit = 1'b1;
          state_next  = IDLE;
        end else begin
          timer_next = timer_reg + 8'd1;
        end
      end
      WAIT_DONE: begin
        if (!bus.busy) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg       <= IDLE;
      timer_reg       <= '0;
      rd_ptr_reg      <= '0;
      wr_ptr_reg      <= '0;
      count_reg       <= '0;
      send_data_reg   <= 8'h00;
      start_reg       <= 1'b0;
      overflow_reg    <= 1'b0;
      ack_timeout_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      timer_reg <= timer_next;
      start_reg <= pop;
      if (pop) begin
        send_data_reg <= mem[rd_ptr_reg];
        rd_ptr_reg    <= rd_ptr_reg + ADDR_W'(1);
      end
      if (push) wr_ptr_reg <= wr_ptr_reg + ADDR_W'(1);
      if (push && !pop)      count_reg <= count_reg + (ADDR_W + 1)'(1);
      else if (pop && !push) count_reg <= count_reg - (ADDR_W + 1)'(1);
      // Set beats clear when both happen on the same edge.
      overflow_reg    <= drop || (overflow_reg && !bus.clr_flags);
      ack_timeout_reg <= timeout_hit || (ack_timeout_reg && !bus.clr_flags);
    end
  end

  // Storage has no reset so it maps onto block RAM; read is the registered send_data.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr_reg] <= bus.wr_data;
  end

  assign bus.full        = full;
  assign bus.empty       = empty;
  assign bus.count       = count_reg;
  assign bus.overflow    = overflow_reg;
  assign bus.ack_timeout = ack_timeout_reg;
  assign bus.send_data   = send_data_reg;
  assign bus.start       = start_reg;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: queue-based reference model compared every cycle,
// a small randomized uart responder, and directed literal checks.
module tb_uart_tx_fifo;
  localparam int ADDR_W      = 4;
  localparam int ACK_TIMEOUT = 8;
  localparam int DEPTH       = 1 << ADDR_W;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  uart_tx_fifo_if #(.ADDR_W(ADDR_W)) bus ();

  uart_tx_fifo #(.ADDR_W(ADDR_W), .ACK_TIMEOUT(ACK_TIMEOUT)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  // Reference model: FIFO contents as a queue, the dispatcher as
  // "a byte is outstanding / acknowledged / how long we have waited".
  logic [7:0] q[$];
  logic [7:0] m_send;
  bit         m_start, m_ovf, m_tmo, m_pending, m_acked;
  int         m_wait;

  logic [7:0] rx[$];
  int         start_seen = 0;
  int         ack_cnt = -1;
  int         busy_cnt = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void model_reset();
    q.delete();
    m_send    = 8'h00;
    m_start   = 1'b0;
    m_ovf     = 1'b0;
    m_tmo     = 1'b0;
    m_pending = 1'b0;
    m_acked   = 1'b0;
    m_wait    = 0;
  endfunction

  function automatic void model_step();
    bit b, pop, accept, tmo_set;
    b       = bus.busy;
    pop     = !m_pending && (q.size() != 0) && !b;
    tmo_set = 1'b0;
    if (m_pending) begin
      if (!m_acked) begin
        if (b) m_acked = 1'b1;
        else if (m_wait == ACK_TIMEOUT - 1) begin
          tmo_set   = 1'b1;
          m_pending = 1'b0;
        end else m_wait++;
      end else if (!b) begin
        m_pending = 1'b0;
      end
    end
    accept = bus.wr_en && ((q.size() < DEPTH) || pop);
    if (pop) begin
      m_send    = q.pop_front();
      m_pending = 1'b1;
      m_acked   = 1'b0;
      m_wait    = 0;
    end
    if (accept) q.push_back(bus.wr_data);
    m_start = pop;
    m_ovf   = (bus.wr_en && !accept) || (m_ovf && !bus.clr_flags);
    m_tmo   = tmo_set || (m_tmo && !bus.clr_flags);
  endfunction

  always @(posedge clock) begin
    if (reset) model_step();
    else model_reset();
  end

  // Compare process: outputs are stable on the falling edge.
  always @(negedge clock) begin
    check("count",       32'(bus.count),       32'(q.size()));
    check("full",        32'(bus.full),        32'(q.size() == DEPTH));
    check("empty",       32'(bus.empty),       32'(q.size() == 0));
    check("start",       32'(bus.start),       32'(m_start));
    check("send_data",   32'(bus.send_data),   32'(m_send));
    check("overflow",    32'(bus.overflow),    32'(m_ovf));
    check("ack_timeout", 32'(bus.ack_timeout), 32'(m_tmo));
    if (bus.start === 1'b1) begin
      rx.push_back(bus.send_data);
      start_seen++;
      $display("tx %0d: byte %02h at %0t", start_seen, bus.send_data, $time);
    end
  end

  task automatic tick(input bit w, input logic [7:0] d, input bit c, input bit b);
    @(negedge clock);
    bus.wr_en     = w;
    bus.wr_data   = d;
    bus.clr_flags = c;
    bus.busy      = b;
    @(posedge clock);
    #1;
  endtask

  // One cycle with a uart that acknowledges after a random delay
  // (occasionally too late) and stays busy for a random length.
  task automatic uart_cycle(input bit w, input logic [7:0] d, input bit c);
    bit b;
    if (m_start)
      ack_cnt = ($urandom_range(0, 9) == 0) ? ACK_TIMEOUT + 2 : int'($urandom_range(0, 3));
    if (ack_cnt == 0) begin
      busy_cnt = int'($urandom_range(1, 6));
      ack_cnt  = -1;
    end else if (ack_cnt > 0) begin
      ack_cnt--;
    end
    b = (busy_cnt > 0);
    if (busy_cnt > 0) busy_cnt--;
    tick(w, d, c, b);
  endtask

  task automatic drain();
    int n = 0;
    while ((q.size() != 0 || m_pending || ack_cnt >= 0 || busy_cnt > 0) && n < 3000) begin
      uart_cycle(1'b0, 8'h00, 1'b0);
      n++;
    end
    check("drain_done", 32'(n < 3000), 32'd1);
    tick(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic check_reset_values(string tag);
    check({tag, "_count"}, 32'(bus.count),       32'd0);
    check({tag, "_empty"}, 32'(bus.empty),       32'd1);
    check({tag, "_full"},  32'(bus.full),        32'd0);
    check({tag, "_start"}, 32'(bus.start),       32'd0);
    check({tag, "_data"},  32'(bus.send_data),   32'h00);
    check({tag, "_ovf"},   32'(bus.overflow),    32'd0);
    check({tag, "_tmo"},   32'(bus.ack_timeout), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, expected finish before %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int snap;
    bus.wr_en     = 1'b0;
    bus.wr_data   = 8'h00;
    bus.clr_flags = 1'b0;
    bus.busy      = 1'b0;
    model_reset();
    #1 reset = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b1;
    #1;
    check_reset_values("rst");

    // Single byte: start at edge k+1 for one cycle.
    rx.delete();
    tick(1'b1, 8'hAA, 1'b0, 1'b0);
    check("single_count_k", 32'(bus.count), 32'd1);
    check("single_start_k", 32'(bus.start), 32'd0);
    tick(1'b0, 8'h00, 1'b0, 1'b0);
    check("single_start", 32'(bus.start),     32'd1);
    check("single_data",  32'(bus.send_data), 32'hAA);
    check("single_count", 32'(bus.count),     32'd0);
    check("single_empty", 32'(bus.empty),     32'd1);
    tick(1'b0, 8'h00, 1'b0, 1'b1);
    check("single_start_off", 32'(bus.start), 32'd0);
    tick(1'b0, 8'h00, 1'b0, 1'b1);
    tick(1'b0, 8'h00, 1'b0, 1'b0);
    check("single_rx_n",  32'(rx.size()), 32'd1);
    check("single_hold",  32'(bus.send_data), 32'hAA);

    // Burst of four on consecutive cycles.
    rx.delete();
    uart_cycle(1'b1, 8'h55, 1'b0);
    uart_cycle(1'b1, 8'hAA, 1'b0);
    uart_cycle(1'b1, 8'h0F, 1'b0);
    uart_cycle(1'b1, 8'hF0, 1'b0);
    drain();
    check("burst_n",  32'(rx.size()), 32'd4);
    if (rx.size() == 4) begin
      check("burst_0", 32'(rx[0]), 32'h55);
      check("burst_1", 32'(rx[1]), 32'hAA);
      check("burst_2", 32'(rx[2]), 32'h0F);
      check("burst_3", 32'(rx[3]), 32'hF0);
    end

    // Fill with busy held, overflow, then write during the pop to wrap.
    rx.delete();
    for (int i = 0; i < 17; i++) begin
      tick(1'b1, 8'(i), 1'b0, 1'b1);
      if (i == 15) begin
        check("fill_full",  32'(bus.full),  32'd1);
        check("fill_count", 32'(bus.count), 32'd16);
        check("fill_ovf0",  32'(bus.overflow), 32'd0);
      end
    end
    check("ovf_set",   32'(bus.overflow), 32'd1);
    check("ovf_count", 32'(bus.count),    32'd16);
    tick(1'b1, 8'h77, 1'b0, 1'b0);
    check("wrap_count", 32'(bus.count),     32'd16);
    check("wrap_full",  32'(bus.full),      32'd1);
    check("wrap_start", 32'(bus.start),     32'd1);
    check("wrap_data",  32'(bus.send_data), 32'h00);
    drain();
    check("wrap_rx_n", 32'(rx.size()), 32'd17);
    if (rx.size() == 17) begin
      check("wrap_rx_first", 32'(rx[0]),  32'h00);
      check("wrap_rx_0f",    32'(rx[15]), 32'h0F);
      check("wrap_rx_last",  32'(rx[16]), 32'h77);
    end
    tick(1'b0, 8'h00, 1'b1, 1'b0);
    check("ovf_clear", 32'(bus.overflow), 32'd0);

    // Ack timeout with busy tied low.
    tick(1'b1, 8'h3C, 1'b0, 1'b0);
    tick(1'b0, 8'h00, 1'b0, 1'b0);
    check("tmo_start", 32'(bus.start),     32'd1);
    check("tmo_data",  32'(bus.send_data), 32'h3C);
    repeat (ACK_TIMEOUT - 1) tick(1'b0, 8'h00, 1'b0, 1'b0);
    check("tmo_early", 32'(bus.ack_timeout), 32'd0);
    tick(1'b0, 8'h00, 1'b0, 1'b0);
    check("tmo_set",   32'(bus.ack_timeout), 32'd1);
    check("tmo_empty", 32'(bus.empty),       32'd1);
    tick(1'b0, 8'h00, 1'b1, 1'b0);
    check("tmo_clear", 32'(bus.ack_timeout), 32'd0);

    // Randomized traffic: light load, then heavy load that overflows.
    for (int i = 0; i < 900; i++) begin
      uart_cycle(($urandom_range(0, 99) < ((i < 450) ? 30 : 85)),
                 8'($urandom), ($urandom_range(0, 15) == 0));
    end
    drain();

    // Asynchronous reset mid-transmission with five bytes queued.
    for (int i = 1; i <= 6; i++) tick(1'b1, 8'(i), 1'b0, 1'b1);
    tick(1'b0, 8'h00, 1'b0, 1'b0);
    tick(1'b0, 8'h00, 1'b0, 1'b1);
    check("arst_pre_count", 32'(bus.count), 32'd5);
    @(negedge clock);
    #2 reset = 1'b0;
    model_reset();
    #1;
    check_reset_values("arst");
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset    = 1'b1;
    bus.busy = 1'b0;
    ack_cnt  = -1;
    busy_cnt = 0;
    snap = start_seen;
    repeat (5) tick(1'b0, 8'h00, 1'b0, 1'b0);
    check("arst_no_start", 32'(start_seen), 32'(snap));
    tick(1'b1, 8'h5A, 1'b0, 1'b0);
    tick(1'b0, 8'h00, 1'b0, 1'b0);
    check("arst_restart", 32'(bus.start),     32'd1);
    check("arst_data",    32'(bus.send_data), 32'h5A);
    tick(1'b0, 8'h00, 1'b0, 1'b1);
    tick(1'b0, 8'h00, 1'b0, 1'b0);
    tick(1'b0, 8'h00, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
